// File: rtl/rounding_pkg.sv
// rounding_pkg: shared types and the rounding-increment helper for rounding_pipe.
package rounding_pkg;

   typedef enum logic [1:0] {
      RND_TRUNC     = 2'd0,
      RND_HALF_UP   = 2'd1,
      RND_HALF_EVEN = 2'd2,
      RND_RSVD      = 2'd3
   } rnd_mode_e;

   // Widest dropped-bit field the helper handles (IN_W - OUT_W must be below this).
   localparam int unsigned RND_MAX_D = 32;

   // Increment added to the widened sample before the arithmetic shift by d.
   // Half-up always adds half an LSB; half-even adds it except on an exact tie
   // whose kept LSB is already even, so the tie falls to the even result.
   function automatic logic [RND_MAX_D-1:0] rnd_increment(
      input rnd_mode_e              mode,
      input logic [RND_MAX_D-1:0]   dropped,
      input int unsigned            d,
      input logic                   lsb
   );
      logic [RND_MAX_D-1:0] half;
      logic [RND_MAX_D-1:0] inc;
      half = RND_MAX_D'(1) << (d - 1);
      inc  = '0;
      case (mode)
         RND_HALF_UP:   inc = half;
         RND_HALF_EVEN: inc = ((dropped == half) && !lsb) ? '0 : half;
         default:       inc = '0;
      endcase
      return inc;
   endfunction

endpackage

// File: rtl/rounding_core.sv
// rounding_core: combinational widening and rounding-increment add.
// The sum is IN_W+1 bits wide so the increment can never wrap the sample.
module rounding_core
   import rounding_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 12
) (
   input  logic [IN_W-1:0] i_data,
   input  logic [1:0]      i_mode,
   output logic [IN_W:0]   o_sum
);

   localparam int unsigned D = IN_W - OUT_W;

   logic [RND_MAX_D-1:0] w_dropped;
   logic [RND_MAX_D-1:0] w_inc;
   logic                 w_unused_inc_hi;

   assign w_dropped = {{(RND_MAX_D - D){1'b0}}, i_data[D-1:0]};
   assign w_inc     = rnd_increment(rnd_mode_e'(i_mode), w_dropped, D, i_data[D]);

   // The increment is at most half an output LSB, so it fits in D bits.
   assign w_unused_inc_hi = ^w_inc[RND_MAX_D-1:D];

   assign o_sum = {i_data[IN_W-1], i_data} + {{(OUT_W + 1){1'b0}}, w_inc[D-1:0]};

endmodule

// File: rtl/rounding_pipe.sv
// rounding_pipe: two-stage signed narrowing IN_W -> OUT_W with selectable rounding.
// Build option: define ROUNDING_PIPE_SAT_EN to clamp overflowing results to the
// positive maximum; without it the low OUT_W bits of the shifted sum are output.
// Overflow is flagged (out_ovf, ovf_sticky) in both builds.
//
// Handshake: a transfer happens on any cycle where valid && ready. out_valid,
// out_data and out_ovf hold until out_ready. Both stages advance together when
// the output slot is empty or being consumed; in_ready equals that advance
// condition and never depends on in_valid.
module rounding_pipe
   import rounding_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       rnd_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_ovf,
   output logic             ovf_sticky,
   input  logic             ovf_clr
);

   localparam int D = IN_W - OUT_W;
   localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};

   logic [IN_W:0]    w_sum;
   logic             w_advance;
   logic [OUT_W:0]   w_shift;
   logic             w_ovf;
   logic [OUT_W-1:0] w_res;
   logic             w_unused_s1;

   logic             r_s1_valid;
   logic [IN_W:0]    r_s1_sum;
   logic [1:0]       r_s1_mode;
   logic             r_out_valid;
   logic [OUT_W-1:0] r_out_data;
   logic             r_out_ovf;
   logic             r_ovf_sticky;

   rounding_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .i_data (in_data),
      .i_mode (rnd_mode),
      .o_sum  (w_sum)
   );

   assign w_advance = !r_out_valid || out_ready;
   assign in_ready  = w_advance;

   // Dropping the D LSBs of the rounded sum; it can only exceed the positive
   // range by exactly one (sign 0, next bit 1), negative overflow is impossible.
   assign w_shift = r_s1_sum[IN_W:D];
   assign w_ovf   = !w_shift[OUT_W] && w_shift[OUT_W-1];

`ifdef ROUNDING_PIPE_SAT_EN
   assign w_res = w_ovf ? OUT_MAX : w_shift[OUT_W-1:0];
`else
   assign w_res = w_shift[OUT_W-1:0];
`endif

   // The dropped bits and the stage-1 mode are kept for observability only.
   assign w_unused_s1 = ^{r_s1_sum[D-1:0], r_s1_mode, OUT_MAX};

   // Stage 1: capture the rounded wide sum and mode on every advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_sum   <= '0;
         r_s1_mode  <= '0;
      end else if (w_advance) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_sum  <= w_sum;
            r_s1_mode <= rnd_mode;
         end
      end
   end

   // Stage 2: shifted, optionally saturated result and its overflow marker.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ovf   <= 1'b0;
      end else if (w_advance) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_data <= w_res;
            r_out_ovf  <= w_ovf;
         end
      end
   end

   // Sticky overflow: set by an overflowing output transfer, which beats a clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf_sticky <= 1'b0;
      end else if (r_out_valid && out_ready && r_out_ovf) begin
         r_ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
         r_ovf_sticky <= 1'b0;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_ovf    = r_out_ovf;
   assign ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_rounding_pipe.sv
// tb_rounding_pipe: directed and randomized checks of rounding_pipe against an
// arithmetic reference model (floor division plus remainder comparison).
module tb_rounding_pipe;

   localparam int IN_W  = 16;
   localparam int OUT_W = 12;
   localparam int D     = IN_W - OUT_W;

   // ---------------- clock / reset / signals ----------------
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [IN_W-1:0]  in_data = '0;
   logic [1:0]       rnd_mode = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [OUT_W-1:0] out_data;
   logic             out_ovf;
   logic             ovf_sticky;
   logic             ovf_clr = 1'b0;

   always #5 clk = ~clk;

   rounding_pipe #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .rnd_mode   (rnd_mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_ovf    (out_ovf),
      .ovf_sticky (ovf_sticky),
      .ovf_clr    (ovf_clr)
   );

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic lat_chk = 1'b0;

   logic [OUT_W:0]   exp_q[$];   // {ovf, data} from the reference model
   logic [OUT_W+1:0] dir_q[$];   // {has_directed, ovf, data} from the test plan
   int               acc_q[$];   // acceptance cycle per sample
   logic [OUT_W+1:0] cur_dir = '0;
   logic             exp_sticky = 1'b0;
   logic             prev_stall = 1'b0;
   logic [OUT_W-1:0] prev_data = '0;
   logic             prev_ovf = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: floor(x / 2^D) then round using the remainder.
   function automatic logic [OUT_W:0] model(input logic [IN_W-1:0] d, input logic [1:0] m);
      longint x, q, r, half, maxv;
      logic   ovf;
      logic [63:0] qb;
      x    = longint'($signed(d));
      half = longint'(1) << (D - 1);
      maxv = (longint'(1) << (OUT_W - 1)) - 1;
      q    = x >>> D;
      r    = x - q * (longint'(1) << D);
      if (m == 2'd1 && r >= half) q = q + 1;
      if (m == 2'd2 && (r > half || (r == half && (q % 2 != 0)))) q = q + 1;
      ovf = (q > maxv);
`ifdef ROUNDING_PIPE_SAT_EN
      if (ovf) q = maxv;
`endif
      qb = 64'(q);
      return {ovf, qb[OUT_W-1:0]};
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // ---------------- scoreboard / monitor (negedge sampling) ----------------
   initial begin
      logic [OUT_W:0]   e;
      logic [OUT_W+1:0] dv;
      int               a;
      logic             set_now;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            dir_q.delete();
            acc_q.delete();
            exp_sticky = 1'b0;
            prev_stall = 1'b0;
         end else begin
            set_now = 1'b0;
            if (prev_stall) begin
               check("stall_valid_hold", 32'(out_valid), 32'd1);
               check("stall_data_hold", 32'(out_data), 32'(prev_data));
               check("stall_ovf_hold", 32'(out_ovf), 32'(prev_ovf));
            end
            check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            check("ovf_sticky", 32'(ovf_sticky), 32'(exp_sticky));
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("spurious_output", 32'd1, 32'd0);
               end else begin
                  e  = exp_q.pop_front();
                  dv = dir_q.pop_front();
                  a  = acc_q.pop_front();
                  check("out_data", 32'(out_data), 32'(e[OUT_W-1:0]));
                  check("out_ovf", 32'(out_ovf), 32'(e[OUT_W]));
                  if (dv[OUT_W+1]) begin
                     check("plan_data", 32'(out_data), 32'(dv[OUT_W-1:0]));
                     check("plan_ovf", 32'(out_ovf), 32'(dv[OUT_W]));
                  end
                  if (lat_chk) check("latency", 32'(cyc - a), 32'd2);
                  set_now = e[OUT_W];
               end
            end
            if (set_now) exp_sticky = 1'b1;
            else if (ovf_clr) exp_sticky = 1'b0;
            if (in_valid && in_ready) begin
               exp_q.push_back(model(in_data, rnd_mode));
               dir_q.push_back(cur_dir);
               acc_q.push_back(cyc);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_ovf   = out_ovf;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [IN_W-1:0] d, input logic [1:0] m,
                       input logic has_dir, input logic [OUT_W:0] dir_val);
      logic acc;
      cur_dir  = {has_dir, dir_val};
      in_valid = 1'b1;
      in_data  = d;
      rnd_mode = m;
      acc = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1'b1;
            break;
         end
      end
      if (!acc) check("send_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      logic done;
      done = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #2;
         if (exp_q.size() == 0 && !out_valid) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) check("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic run_random(input int n, input logic bubbles);
      logic [IN_W-1:0] corners[8];
      logic            done;
      corners = '{16'h7FF8, 16'h7FFF, 16'h8000, 16'h0008, 16'hFFF8, 16'h0018, 16'h7FF7, 16'hFFFF};
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < n; i++) begin
               if (bubbles && $urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               if ($urandom_range(0, 3) == 0)
                  send(corners[$urandom_range(0, 7)], 2'($urandom_range(0, 3)), 1'b0, '0);
               else
                  send(16'($urandom), 2'($urandom_range(0, 3)), 1'b0, '0);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom_range(0, 1));
               ovf_clr   = ($urandom_range(0, 7) == 0);
            end
            ovf_clr = 1'b0;
         end
      join
      wait_idle();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_ovf", 32'(out_ovf), 32'd0);
      check("rst_ovf_sticky", 32'(ovf_sticky), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;

      // Directed cases with latency checking (out_ready held high).
      lat_chk = 1'b1;
      send(16'h99C0, 2'd1, 1'b1, {1'b0, 12'h99C});
      send(16'h99C3, 2'd1, 1'b1, {1'b0, 12'h99C});
      send(16'h0018, 2'd0, 1'b1, {1'b0, 12'h001});
      send(16'h0028, 2'd0, 1'b1, {1'b0, 12'h002});
      send(16'h0018, 2'd1, 1'b1, {1'b0, 12'h002});
      send(16'h0028, 2'd1, 1'b1, {1'b0, 12'h003});
      send(16'h0018, 2'd2, 1'b1, {1'b0, 12'h002});
      send(16'h0028, 2'd2, 1'b1, {1'b0, 12'h002});
      send(16'h0018, 2'd3, 1'b1, {1'b0, 12'h001});
      send(16'hFFF3, 2'd1, 1'b1, {1'b0, 12'hFFF});
      send(16'hF9F3, 2'd1, 1'b1, {1'b0, 12'hF9F});
      send(16'hFFF8, 2'd1, 1'b1, {1'b0, 12'h000});
      wait_idle();
      check("sticky_clear_before_ovf", 32'(ovf_sticky), 32'd0);

`ifdef ROUNDING_PIPE_SAT_EN
      send(16'h7FF8, 2'd1, 1'b1, {1'b1, 12'h7FF});
      send(16'h7FF8, 2'd2, 1'b1, {1'b1, 12'h7FF});
`else
      send(16'h7FF8, 2'd1, 1'b1, {1'b1, 12'h800});
      send(16'h7FF8, 2'd2, 1'b1, {1'b1, 12'h800});
`endif
      wait_idle();
      check("sticky_after_ovf", 32'(ovf_sticky), 32'd1);
      ovf_clr = 1'b1;
      @(posedge clk);
      #1;
      ovf_clr = 1'b0;
      check("sticky_after_clr", 32'(ovf_sticky), 32'd0);

      // Clear held across an overflowing transfer: the set must win.
      ovf_clr = 1'b1;
      send(16'h7FF8, 2'd1, 1'b0, '0);
      wait_idle();
      ovf_clr = 1'b0;
      lat_chk = 1'b0;

      // Backpressure: 10 samples, then a longer stream with bubbles.
      run_random(10, 1'b0);
      run_random(150, 1'b1);

      // Reset with two samples in flight.
      out_ready = 1'b0;
      send(16'h1234, 2'd1, 1'b0, '0);
      send(16'h5678, 2'd2, 1'b0, '0);
      check("inflight_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_out_data", 32'(out_data), 32'd0);
      out_ready = 1'b1;
      lat_chk = 1'b1;
      send(16'h0028, 2'd2, 1'b1, {1'b0, 12'h002});
      wait_idle();
      lat_chk = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
